// File: rtl/watch_pkg.sv
// Shared encodings for the stopwatch command controller: FSM states,
// ASCII command bytes and small width helpers.
package watch_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  localparam logic [BYTE_W-1:0] CH_RUN   = 8'h72;  // 'r'
  localparam logic [BYTE_W-1:0] CH_STOP  = 8'h73;  // 's'
  localparam logic [BYTE_W-1:0] CH_CLEAR = 8'h63;  // 'c'
  localparam logic [BYTE_W-1:0] CH_MODE  = 8'h6D;  // 'm'
  localparam logic [BYTE_W-1:0] CH_LAP   = 8'h6C;  // 'l'
  localparam logic [BYTE_W-1:0] CH_ZERO  = 8'h30;  // '0'
  localparam logic [BYTE_W-1:0] CH_NINE  = 8'h39;  // '9'

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [BYTE_W-1:0] fold_case(input logic [BYTE_W-1:0] b, input logic en);
    if (en && (b >= 8'h41) && (b <= 8'h5A))
      return b | 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_fetch.sv
// Pops one byte at a time from a first-word-fall-through FIFO and holds it
// as a pending command until the controller consumes it.
module uart_cmd_fetch
  import watch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_empty,
  input  logic              consume,
  output logic              rd_en,
  output logic [BYTE_W-1:0] cmd,
  output logic              pending
);

  // A pop is never issued while a byte is still waiting, so capture and consume never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en   <= 1'b0;
      cmd     <= '0;
      pending <= 1'b0;
    end else begin
      rd_en <= !rx_empty && !rd_en && !pending;
      if (rd_en) begin
        cmd     <= rx_data;
        pending <= 1'b1;
      end else if (consume) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/watch_cmd_ctrl.sv
// Run/stop/clear/mode controller merging button pulses with UART commands
// and driving the counter enable/clear, display mode and lap freeze.
module watch_cmd_ctrl
  import watch_pkg::*;
#(
  parameter int MODE_CNT   = 2,
  parameter int CLEAR_CYC  = 1,
  parameter int CLR_IN_RUN = 0,
  parameter int CASE_INS   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          btn_run_stop,
  input  logic                          btn_clear,
  input  logic                          btn_mode,
  input  logic                          btn_lap,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_empty,
  output logic                          rd_en,
  output logic                          enable,
  output logic                          clear,
  output logic [width_of(MODE_CNT)-1:0] mode_sel,
  output logic                          lap_freeze,
  output logic                          cmd_err
);

  localparam int MW = width_of(MODE_CNT);
  localparam int CW = width_of(CLEAR_CYC);

  state_t            state, state_nxt;
  logic [CW-1:0]     clr_cnt, cnt_nxt;
  logic [MW-1:0]     mode_nxt;
  logic              lap_nxt;
  logic [BYTE_W-1:0] cmd_byte, ch, digit;
  logic              pending, btn_any, take_cmd;
  logic              ev_toggle, ev_run, ev_stop, ev_clear, ev_mode, ev_lap, ev_set, ev_err;

  uart_cmd_fetch u_fetch (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_empty (rx_empty),
    .consume  (take_cmd),
    .rd_en    (rd_en),
    .cmd      (cmd_byte),
    .pending  (pending)
  );

  // Buttons take precedence; a pending byte simply waits for a quiet cycle.
  always_comb begin
    btn_any   = btn_run_stop | btn_clear | btn_mode | btn_lap;
    take_cmd  = pending && !btn_any;
    ch        = fold_case(cmd_byte, CASE_INS != 0);
    digit     = ch - CH_ZERO;
    ev_toggle = 1'b0;
    ev_run    = 1'b0;
    ev_stop   = 1'b0;
    ev_clear  = 1'b0;
    ev_mode   = 1'b0;
    ev_lap    = 1'b0;
    ev_set    = 1'b0;
    ev_err    = 1'b0;
    if (btn_any) begin
      ev_toggle = btn_run_stop;
      ev_clear  = btn_clear && !btn_run_stop;
      ev_mode   = btn_mode;
      ev_lap    = btn_lap;
    end else if (take_cmd) begin
      case (ch)
        CH_RUN:   ev_run   = 1'b1;
        CH_STOP:  ev_stop  = 1'b1;
        CH_CLEAR: ev_clear = 1'b1;
        CH_MODE:  ev_mode  = 1'b1;
        CH_LAP:   ev_lap   = 1'b1;
        default: begin
          if ((ch >= CH_ZERO) && (ch <= CH_NINE) && (digit < 8'(MODE_CNT)))
            ev_set = 1'b1;
          else
            ev_err = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = clr_cnt;
    lap_nxt   = lap_freeze;
    case (state)
      ST_STOP: begin
        if (ev_toggle || ev_run) begin
          state_nxt = ST_RUN;
        end else if (ev_clear) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = CW'(CLEAR_CYC - 1);
        end
      end
      ST_RUN: begin
        if (ev_toggle || ev_stop) begin
          state_nxt = ST_STOP;
          lap_nxt   = 1'b0;
        end else if (ev_clear && (CLR_IN_RUN != 0)) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = CW'(CLEAR_CYC - 1);
          lap_nxt   = 1'b0;
        end else if (ev_lap) begin
          lap_nxt = !lap_freeze;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt == '0)
          state_nxt = ST_STOP;
        else
          cnt_nxt = clr_cnt - 1'b1;
      end
      default: state_nxt = ST_STOP;
    endcase

    mode_nxt = mode_sel;
    if (ev_mode)
      mode_nxt = (mode_sel == MW'(MODE_CNT - 1)) ? '0 : mode_sel + 1'b1;
    else if (ev_set)
      mode_nxt = MW'(digit);
  end

  // Outputs are decoded from the next state so they change right after the deciding edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_STOP;
      clr_cnt    <= '0;
      enable     <= 1'b0;
      clear      <= 1'b0;
      mode_sel   <= '0;
      lap_freeze <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= cnt_nxt;
      enable     <= (state_nxt == ST_RUN);
      clear      <= (state_nxt == ST_CLEAR);
      mode_sel   <= mode_nxt;
      lap_freeze <= lap_nxt;
      cmd_err    <= ev_err;
    end
  end

endmodule

// File: tb/tb_watch_cmd_ctrl.sv
// Directed and randomized bench for watch_cmd_ctrl, checked against a
// cycle-level behavioural model of the watch and its FIFO fetch.
module tb_watch_cmd_ctrl;

  localparam int MODE_CNT   = 3;
  localparam int CLEAR_CYC  = 4;
  localparam int CLR_IN_RUN = 0;
  localparam int MW         = (MODE_CNT > 2) ? $clog2(MODE_CNT) : 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          btn_run_stop = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0, btn_lap = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_empty = 1'b1;
  logic          rd_en, enable, clear, lap_freeze, cmd_err;
  logic [MW-1:0] mode_sel;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo_q[$];

  // Model state: fetch handshake, running flag, remaining clear cycles, mode, lap, error pulse.
  bit         m_rd, m_pend, m_run, m_lap, m_err;
  logic [7:0] m_cmd;
  int         m_clr_left, m_mode;

  watch_cmd_ctrl #(
    .MODE_CNT   (MODE_CNT),
    .CLEAR_CYC  (CLEAR_CYC),
    .CLR_IN_RUN (CLR_IN_RUN),
    .CASE_INS   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_run_stop (btn_run_stop),
    .btn_clear    (btn_clear),
    .btn_mode     (btn_mode),
    .btn_lap      (btn_lap),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rd_en        (rd_en),
    .enable       (enable),
    .clear        (clear),
    .mode_sel     (mode_sel),
    .lap_freeze   (lap_freeze),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_rd = 0; m_pend = 0; m_run = 0; m_lap = 0; m_err = 0;
    m_cmd = 8'h00; m_clr_left = 0; m_mode = 0;
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic modelStep();
    bit btn, go, halt, toggle, clr, inc, lap, err, nxt_rd, nxt_pend;
    logic [7:0] ch;
    int set_to;
    btn = btn_run_stop | btn_clear | btn_mode | btn_lap;
    go = 0; halt = 0; toggle = 0; clr = 0; inc = 0; lap = 0; err = 0; set_to = -1;
    if (btn) begin
      toggle = btn_run_stop;
      clr    = btn_clear && !btn_run_stop;
      inc    = btn_mode;
      lap    = btn_lap;
    end else if (m_pend) begin
      ch = m_cmd;
      if (ch >= "A" && ch <= "Z") ch = ch + 8'd32;
      if (ch == "r") go = 1;
      else if (ch == "s") halt = 1;
      else if (ch == "c") clr = 1;
      else if (ch == "m") inc = 1;
      else if (ch == "l") lap = 1;
      else if (ch >= "0" && ch <= "9" && (int'(ch) - 48) < MODE_CNT) set_to = int'(ch) - 48;
      else err = 1;
    end

    nxt_pend = m_pend && btn;
    nxt_rd   = !rx_empty && !m_rd && !m_pend;
    if (m_rd) begin
      m_cmd = rx_data;
      void'(fifo_q.pop_front());
      nxt_pend = 1;
    end
    m_rd   = nxt_rd;
    m_pend = nxt_pend;

    if (m_clr_left > 0) begin
      m_clr_left--;
    end else if (m_run) begin
      if (toggle || halt) begin
        m_run = 0; m_lap = 0;
      end else if (clr && CLR_IN_RUN != 0) begin
        m_run = 0; m_lap = 0; m_clr_left = CLEAR_CYC;
      end else if (lap) begin
        m_lap = !m_lap;
      end
    end else begin
      if (toggle || go) m_run = 1;
      else if (clr) m_clr_left = CLEAR_CYC;
    end

    if (inc) m_mode = (m_mode + 1) % MODE_CNT;
    else if (set_to >= 0) m_mode = set_to;
    m_err = err;
  endtask

  task automatic applyStimulus(input logic rs, input logic cl, input logic md, input logic lp,
                               input logic push, input logic [7:0] b, input logic rst);
    @(negedge clk);
    checkOutput("enable",     8'(enable),     8'(m_run));
    checkOutput("clear",      8'(clear),      8'(m_clr_left > 0));
    checkOutput("mode_sel",   8'(mode_sel),   8'(m_mode));
    checkOutput("lap_freeze", 8'(lap_freeze), 8'(m_lap));
    checkOutput("rd_en",      8'(rd_en),      8'(m_rd));
    checkOutput("cmd_err",    8'(cmd_err),    8'(m_err));
    if (push) fifo_q.push_back(b);
    rx_empty = (fifo_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : fifo_q[0];
    if (rst) begin
      btn_run_stop = 0; btn_clear = 0; btn_mode = 0; btn_lap = 0;
      reset = 1'b1;
      #1;
      checkOutput("async_clear",  8'(clear),  8'h00);
      checkOutput("async_enable", 8'(enable), 8'h00);
      modelReset();
    end else begin
      reset = 1'b0;
      btn_run_stop = rs; btn_clear = cl; btn_mode = md; btn_lap = lp;
      modelStep();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(0, 0, 0, 0, 1, b, 0);
  endtask

  initial begin
    string pool;
    int    k;
    modelReset();
    #1 reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    idle(1);
    // Button run/stop toggling.
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 0);
    idle(2);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 0);
    idle(2);
    // UART run then stop, clear with a run arriving mid-clear.
    sendByte("r"); sendByte("s"); idle(8);
    sendByte("c"); idle(1); sendByte("r"); idle(10);
    // Mode stepping, direct select and out-of-range digit.
    sendByte("m"); sendByte("m"); sendByte("m"); idle(10);
    sendByte("2"); idle(4); sendByte("5"); idle(5);
    // Lap button coinciding with a pending stop while running.
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 0); idle(1);
    sendByte("s"); idle(1);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 0); idle(4);
    // Clear ignored in RUN, unknown byte, reset in the middle of a clear.
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 0); idle(1);
    sendByte("c"); idle(4); sendByte("x"); idle(4);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 0); idle(1);
    sendByte("C"); idle(3);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    idle(3);

    pool = "rsclmRSCLM0123456x?";
    for (int i = 0; i < 2000; i++) begin
      k = $urandom_range(0, pool.len() - 1);
      applyStimulus($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 4,
                    $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 6,
                    $urandom_range(0, 99) < 20, pool[k],
                    $urandom_range(0, 299) == 0);
    end
    idle(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
